seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream display stage for the 4-bit free-running counter: captures each new 4-bit count into a 4-digit hex history and drives a time-multiplexed, common-anode 4-digit seven-segment display.
- Sits between the counter (or any 4-bit nibble source) and the board's seg/an/dp pins. All logic runs on the single system clock.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit before the scan advances; legal range >= 2 (100000 gives 1 kHz per digit at 100 MHz; use 4 in simulation).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- value  input  4  nibble from the upstream counter.
- value_valid  input  1  capture strobe, one cycle per new value.
- dp_mask  input  4  decimal-point enables, bit i for digit i.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  anodes, active-low one-hot, registered.
- dp  output  1  decimal point, active-low, registered.

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- Reset state: digit regs d3..d0 = 0, scan index = 0, prescaler = 0, an = 4'b1111, seg = 7'b1111111, dp = 1.
- Capture path:
  - value_valid=1 at an edge shifts the history: d3<=d2, d2<=d1, d1<=d0, d0<=value.
  - value_valid=0 holds the history.
  - A strobe every cycle is legal; every strobe is captured, none are dropped.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the scan index advances 0->1->2->3->0 (wraps mod 4).
  - Width is $clog2(REFRESH_DIV).
- Output registers, loaded every non-reset cycle from the pre-edge scan index idx and digit registers:
  - an <= ~(4'b0001 << idx).
  - seg <= hex decode of d[idx].
  - dp <= ~dp_mask[idx].
  - Outputs therefore lag the index and the digit registers by 1 cycle.
- Timing after reset release:
  - First non-reset edge gives an=1110.
  - an changes every REFRESH_DIV cycles; full frame = 4*REFRESH_DIV cycles.
- Hex decode ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - A capture on the same edge as a scan advance applies both.
  - The next output load uses the shifted digits and the new index.
- Reset mid-scan or mid-capture: all state returns to reset values on that edge, and any value_valid on that edge is ignored.
- Glitch-free: an is never all-zero and never has two bits low in any cycle.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - When loading outputs for digit idx>0, if d[idx] and every higher digit are 0, load seg=7'b1111111 and dp=~dp_mask[idx].
  - an is driven unchanged. d0 is never blanked.
- Undefined: all digits are always decoded, including leading zeros.

Test Plan:
- Reset check: rst=1 for 3 cycles -> an=1111, seg=1111111, dp=1 throughout; first edge after release -> an=1110, seg=1000000.
- Scan timing (REFRESH_DIV=4): no strobes after reset -> an sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles.
- Capture/shift: strobe values 1,2,3,4 on consecutive cycles -> d3..d0=1,2,3,4; digit0 shows 0011001 (4) and digit3 shows 1111001 (1).
- Simultaneous event: strobe value=F on the prescaler-wrap edge -> next cycle shows the new digit's segments from the shifted history, and an has advanced.
- Mid-operation reset: rst during digit2 with history A,b,C,d -> next cycle an=1111, digits=0; after release, digit0 seg=1000000.
- Optional feature: with SEG7_LEADING_ZERO_BLANK_EN, history 0,0,5,0 -> digit3 and digit2 seg=1111111, digit1=0010010, digit0=1000000; without the macro, digit3 and digit2 = 1000000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit hex history with multiplexed common-anode 7-segment scan
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading-zero digits above digit 0).
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value,
    input  logic       value_valid,
    input  logic [3:0] dp_mask,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [3:0]    d [4];
    logic [1:0]    idx;
    logic [PW-1:0] presc;
    logic          blank;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 7'b1000000;
            4'h1: hex_decode = 7'b1111001;
            4'h2: hex_decode = 7'b0100100;
            4'h3: hex_decode = 7'b0110000;
            4'h4: hex_decode = 7'b0011001;
            4'h5: hex_decode = 7'b0010010;
            4'h6: hex_decode = 7'b0000010;
            4'h7: hex_decode = 7'b1111000;
            4'h8: hex_decode = 7'b0000000;
            4'h9: hex_decode = 7'b0010000;
            4'hA: hex_decode = 7'b0001000;
            4'hB: hex_decode = 7'b0000011;
            4'hC: hex_decode = 7'b1000110;
            4'hD: hex_decode = 7'b0100001;
            4'hE: hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd3: blank = (d[3] == 4'h0);
            2'd2: blank = (d[3] == 4'h0) && (d[2] == 4'h0);
            2'd1: blank = (d[3] == 4'h0) && (d[2] == 4'h0) && (d[1] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) d[i] <= 4'h0;
            idx   <= 2'd0;
            presc <= '0;
            an    <= 4'b1111;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
        end else begin
            if (value_valid) begin
                d[3] <= d[2];
                d[2] <= d[1];
                d[1] <= d[0];
                d[0] <= value;
            end
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            // Outputs are loaded from the pre-edge index and digits, so they lag by one cycle.
            an  <= ~(4'b0001 << idx);
            seg <= blank ? 7'b1111111 : hex_decode(d[idx]);
            dp  <= ~dp_mask[idx];
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver against a cycle-count reference model
module tb_seg7_scan_driver;
    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] value = 4'h0;
    logic       value_valid = 1'b0;
    logic [3:0] dp_mask = 4'h0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    seg7_scan_driver #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
        .dp_mask(dp_mask), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;

    logic [6:0] segtab [16];
    int hist [4];       // hist[0] is the newest capture
    int edges;          // non-reset edges since last reset

    initial begin
        segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    end

    function automatic exp_t model_expect();
        exp_t e;
        int   k;
        bit   lead;
        if (rst) begin
            e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
            return e;
        end
        k = (edges / RD) % 4;
        e.an = 4'b1111;
        e.an[k] = 1'b0;
        e.seg = segtab[hist[k]];
        e.dp = ~dp_mask[k];
        lead = (k > 0);
        for (int j = k; j < 4; j++) if (hist[j] != 0) lead = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (lead) e.seg = 7'b1111111;
`else
        if (lead) e.seg = segtab[0];
`endif
        return e;
    endfunction

    task automatic step(input logic r, input logic v, input logic [3:0] val, input logic [3:0] m);
        @(negedge clk);
        rst = r; value_valid = v; value = val; dp_mask = m;
        expq.push_back(model_expect());
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) hist[i] = 0;
            edges = 0;
        end else begin
            edges++;
            if (v) begin
                for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = val;
            end
        end
    endtask

    // Monitor: outputs are refreshed on every edge, so one expectation per edge.
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t an/seg/dp got %b/%b/%b expected %b/%b/%b",
                         $time, an, seg, dp, e.an, e.seg, e.dp);
            end
            checks++;
            if (!(an == 4'b1111 || $countones(~an) == 1)) begin
                errors++;
                $display("FAIL an_onehot t=%0t got %b expected one low bit or 1111", $time, an);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = 0;
        edges = 0;
        // reset, then idle scan through more than one frame
        for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 4'h0);
        for (int i = 0; i < 4 * RD + 4; i++) step(0, 0, 4'h0, 4'h0);
        // back-to-back capture 1,2,3,4 then a full frame
        for (int i = 1; i <= 4; i++) step(0, 1, 4'(i), 4'h0);
        for (int i = 0; i < 4 * RD + 2; i++) step(0, 0, 4'h0, 4'h5);
        // strobe F on a prescaler-wrap edge
        while ((edges % RD) != RD - 1) step(0, 0, 4'h0, 4'h0);
        step(0, 1, 4'hF, 4'h0);
        for (int i = 0; i < RD; i++) step(0, 0, 4'h0, 4'h0);
        // history A,b,C,d then reset while digit 2 is lit, with a strobe on the reset edge
        step(1, 0, 4'h0, 4'h0);
        step(0, 1, 4'hA, 4'h0); step(0, 1, 4'hB, 4'h0);
        step(0, 1, 4'hC, 4'h0); step(0, 1, 4'hD, 4'h0);
        while (((edges / RD) % 4) != 2) step(0, 0, 4'h0, 4'h0);
        step(1, 1, 4'h7, 4'hF);
        for (int i = 0; i < 2 * RD; i++) step(0, 0, 4'h0, 4'h0);
        // history 0,0,5,0 for leading-zero behaviour
        step(1, 0, 4'h0, 4'h0);
        step(0, 1, 4'h0, 4'h0); step(0, 1, 4'h0, 4'h0);
        step(0, 1, 4'h5, 4'h0); step(0, 1, 4'h0, 4'h0);
        for (int i = 0; i < 4 * RD + 2; i++) step(0, 0, 4'h0, 4'h0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 4'($urandom), 4'($urandom));
        step(0, 0, 4'h0, 4'h0);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain queue got %0d pending expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
